// File: rtl/iir_seq_ctrl.sv
// Run-time sequencer for the 1st-order IIR filter: coefficient shadow/active banks,
// source/filter gating, sample accounting, pipeline flush and end-of-run signalling.
module iir_seq_ctrl #(
    parameter int NB       = 10,
    parameter int LAT      = 2,
    parameter int CNT_W    = 16,
    parameter int FLUSH_TO = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CNT_W-1:0]     NSAMP,
    input  logic                 CFG_WE,
    input  logic [1:0]           CFG_ADDR,
    input  logic signed [NB-1:0] CFG_DATA,
    input  logic                 SRC_EOF,
    input  logic                 FLT_VOUT,
    output logic                 SRC_EN,
    output logic                 FLT_VIN,
    output logic signed [NB-1:0] A0,
    output logic signed [NB-1:0] A1,
    output logic signed [NB-1:0] B0,
    output logic signed [NB-1:0] B1,
    output logic                 SINK_EN,
    output logic                 BUSY,
    output logic                 END_SIM,
    output logic                 ERR,
    output logic [CNT_W-1:0]     IN_CNT,
    output logic [CNT_W-1:0]     OUT_CNT
);

    // A timeout shorter than the filter latency could never see the last output.
    localparam int TO_EFF = (FLUSH_TO > LAT) ? FLUSH_TO : LAT + 1;
    localparam int TMR_W  = $clog2(TO_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 err_q, err_d;
    logic [3:0][NB-1:0]   shadow_q, shadow_d;
    logic [3:0][NB-1:0]   active_q, active_d;
    logic                 src_en_q, busy_q, end_sim_q;
    logic                 vin_s, sink_s, last_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    // Next-state, counter, coefficient bank and strobe logic.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        timer_d   = timer_q;
        err_d     = err_q;
        shadow_d  = shadow_q;
        active_d  = active_q;

        vin_s  = (state_q == S_RUN) && !SRC_EOF;
        sink_s = FLT_VOUT && ((state_q == S_RUN) || (state_q == S_FLUSH));
        last_s = (NSAMP != {CNT_W{1'b0}}) &&
                 (({1'b0, in_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, NSAMP});

        if (CFG_WE) begin
            shadow_d[CFG_ADDR] = CFG_DATA;
        end else begin
            shadow_d = shadow_q;
        end

        if (sink_s) begin
            out_cnt_d = sat_inc(out_cnt_q);
        end else begin
            out_cnt_d = out_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD: begin
                // Commit uses the pre-write shadow so a same-cycle write waits a run.
                active_d  = shadow_q;
                in_cnt_d  = {CNT_W{1'b0}};
                out_cnt_d = {CNT_W{1'b0}};
                err_d     = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                timer_d = {TMR_W{1'b0}};
                if (vin_s) in_cnt_d = sat_inc(in_cnt_q);
                else       in_cnt_d = in_cnt_q;
                if (SRC_EOF)             state_d = S_FLUSH;
                else if (vin_s && last_s) state_d = S_FLUSH;
                else                      state_d = S_RUN;
            end
            S_FLUSH: begin
                timer_d = timer_q + TMR_W'(1);
                // Including this cycle's output lets END_SIM follow the last VOUT by one.
                if (out_cnt_d == in_cnt_q) begin
                    state_d = S_DONE;
                end else if (timer_q == TMR_W'(TO_EFF - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                if (START) state_d = S_LOAD;
                else       state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, banks and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= {CNT_W{1'b0}};
            out_cnt_q <= {CNT_W{1'b0}};
            timer_q   <= {TMR_W{1'b0}};
            err_q     <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            src_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            end_sim_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            src_en_q  <= (state_d == S_RUN);
            busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_FLUSH);
            end_sim_q <= (state_d == S_DONE);
        end
    end

    assign SRC_EN  = src_en_q;
    assign FLT_VIN = vin_s;
    assign SINK_EN = sink_s;
    assign BUSY    = busy_q;
    assign END_SIM = end_sim_q;
    assign ERR     = err_q;
    assign IN_CNT  = in_cnt_q;
    assign OUT_CNT = out_cnt_q;
    assign A0      = active_q[0];
    assign A1      = active_q[1];
    assign B0      = active_q[2];
    assign B1      = active_q[3];

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Scenario bench for iir_seq_ctrl with a LAT=2 filter model and a timestamp scoreboard
// that expects each issued sample at the sink exactly two cycles later.
module tb_iir_seq_ctrl;
    localparam int NB    = 10;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             RST = 1'b1, START = 1'b0, CFG_WE = 1'b0, SRC_EOF = 1'b0, FLT_VOUT = 1'b0;
    logic [CNT_W-1:0] NSAMP = '0;
    logic [1:0]       CFG_ADDR = 2'd0;
    logic [NB-1:0]    CFG_DATA = '0;
    logic             SRC_EN, FLT_VIN, SINK_EN, BUSY, END_SIM, ERR;
    logic [NB-1:0]    A0, A1, B0, B1;
    logic [CNT_W-1:0] IN_CNT, OUT_CNT;

    iir_seq_ctrl dut (
        .CLK(clk), .RST(RST), .START(START), .NSAMP(NSAMP), .CFG_WE(CFG_WE),
        .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .SRC_EOF(SRC_EOF), .FLT_VOUT(FLT_VOUT),
        .SRC_EN(SRC_EN), .FLT_VIN(FLT_VIN), .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .SINK_EN(SINK_EN), .BUSY(BUSY), .END_SIM(END_SIM), .ERR(ERR),
        .IN_CNT(IN_CNT), .OUT_CNT(OUT_CNT)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int tb_issue = 0, tb_rx = 0, drop_k = -1;
    int last_vin_cyc = 0, last_sink_cyc = 0;
    int stamp_q[$];
    logic [1:0] hist = 2'b00;
    bit flt_force = 1'b0;
    logic [NB-1:0] sh[4] = '{default: '0};
    logic [NB-1:0] ex[4] = '{default: '0};

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: VIN seen in cycle c returns as VOUT in cycle c+2.
    always @(posedge clk) begin
        #2;
        FLT_VOUT = hist[1] | flt_force;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        bit keep;
        int stamp;
        keep = 1'b0;
        if (FLT_VIN === 1'b1) begin
            n_vec++;
            if (IN_CNT !== CNT_W'(tb_issue)) begin
                n_err++;
                $display("FAIL in_cnt_at_vin: got %0d want %0d", IN_CNT, tb_issue);
            end
            tb_issue++;
            last_vin_cyc = cyc;
            keep = (tb_issue != drop_k);
            if (keep) stamp_q.push_back(cyc);
        end
        hist = {hist[0], keep};
        if (SINK_EN === 1'b1) begin
            n_vec++;
            if (stamp_q.size() == 0) begin
                n_err++;
                $display("FAIL sink_unexpected: got SINK_EN=1 at cycle %0d want 0", cyc);
            end else begin
                stamp = stamp_q.pop_front();
                if (cyc != stamp + 2) begin
                    n_err++;
                    $display("FAIL sink_latency: got cycle %0d want %0d", cyc, stamp + 2);
                end
            end
            n_vec++;
            if (OUT_CNT !== CNT_W'(tb_rx)) begin
                n_err++;
                $display("FAIL out_cnt_at_sink: got %0d want %0d", OUT_CNT, tb_rx);
            end
            tb_rx++;
            last_sink_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [NB-1:0] d);
        tick();
        CFG_WE = 1'b1; CFG_ADDR = a; CFG_DATA = d;
        tick();
        CFG_WE = 1'b0;
        sh[a] = d;
    endtask

    task automatic start_run(input int n, input bit ld_we, input logic [1:0] la, input logic [NB-1:0] ld);
        tick();
        NSAMP = CNT_W'(n); tb_issue = 0; tb_rx = 0; stamp_q.delete(); START = 1'b1;
        tick();
        START = 1'b0;
        CFG_WE = ld_we; CFG_ADDR = la; CFG_DATA = ld;
        n_vec++;
        if (BUSY !== 1'b1 || {A0, A1, B0, B1} !== {ex[0], ex[1], ex[2], ex[3]}) begin
            n_err++;
            $display("FAIL load_hold: got busy=%b coef=%h want busy=1 coef=%h",
                     BUSY, {A0, A1, B0, B1}, {ex[0], ex[1], ex[2], ex[3]});
        end
        ex = sh;
        if (ld_we) sh[la] = ld;
        tick();
        CFG_WE = 1'b0;
        n_vec++;
        if ({A0, A1, B0, B1} !== {ex[0], ex[1], ex[2], ex[3]}) begin
            n_err++;
            $display("FAIL run_coef: got %h want %h", {A0, A1, B0, B1}, {ex[0], ex[1], ex[2], ex[3]});
        end
        n_vec++;
        if ({SRC_EN, END_SIM, ERR} !== 3'b100) begin
            n_err++;
            $display("FAIL run_entry: got src_en/end/err=%b want 100", {SRC_EN, END_SIM, ERR});
        end
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            n_vec++;
            if ({A0, A1, B0, B1} !== {ex[0], ex[1], ex[2], ex[3]}) begin
                n_err++;
                $display("FAIL coef_stable: got %h want %h", {A0, A1, B0, B1}, {ex[0], ex[1], ex[2], ex[3]});
            end
            if (END_SIM === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        n_vec++;
        if (dc < 0) begin
            n_err++;
            $display("FAIL done_timeout: got no END_SIM want END_SIM within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({SRC_EN, FLT_VIN, SINK_EN, BUSY, END_SIM, ERR} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000", {SRC_EN, FLT_VIN, SINK_EN, BUSY, END_SIM, ERR});
        end
        n_vec++;
        if ({A0, A1, B0, B1, IN_CNT, OUT_CNT} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got %h want 0", {A0, A1, B0, B1, IN_CNT, OUT_CNT});
        end
    endtask

    task automatic test_basic();
        int dc;
        cfg_write(2'd0, 10'h200);
        cfg_write(2'd1, 10'd82);
        cfg_write(2'd2, 10'd215);
        cfg_write(2'd3, 10'd215);
        n_vec++;
        if ({A0, A1, B0, B1} !== '0) begin
            n_err++;
            $display("FAIL coef_before_load: got %h want 0", {A0, A1, B0, B1});
        end
        start_run(150, 1'b0, 2'd0, '0);
        wait_done(400, dc);
        n_vec++;
        if (tb_issue != 150) begin
            n_err++; $display("FAIL basic_vin_cycles: got %0d want 150", tb_issue);
        end
        n_vec++;
        if (IN_CNT !== 16'd150 || OUT_CNT !== 16'd150) begin
            n_err++; $display("FAIL basic_counts: got in=%0d out=%0d want 150/150", IN_CNT, OUT_CNT);
        end
        n_vec++;
        if (dc != last_sink_cyc + 1) begin
            n_err++; $display("FAIL basic_end_timing: got cycle %0d want %0d", dc, last_sink_cyc + 1);
        end
        n_vec++;
        if (ERR !== 1'b0 || BUSY !== 1'b0) begin
            n_err++; $display("FAIL basic_done_flags: got err=%b busy=%b want 0/0", ERR, BUSY);
        end
    endtask

    task automatic test_eof();
        int dc;
        start_run(0, 1'b0, 2'd0, '0);
        repeat (37) tick();
        SRC_EOF = 1'b1;
        wait_done(100, dc);
        SRC_EOF = 1'b0;
        n_vec++;
        if (tb_issue != 37 || IN_CNT !== 16'd37) begin
            n_err++; $display("FAIL eof_in_cnt: got vin=%0d in=%0d want 37", tb_issue, IN_CNT);
        end
        n_vec++;
        if (OUT_CNT !== 16'd37 || dc != last_sink_cyc + 1) begin
            n_err++; $display("FAIL eof_end: got out=%0d end_cyc=%0d want 37 / %0d", OUT_CNT, dc, last_sink_cyc + 1);
        end
    endtask

    task automatic test_zero();
        int dc, run_c;
        SRC_EOF = 1'b1;
        start_run(0, 1'b0, 2'd0, '0);
        run_c = cyc;
        wait_done(20, dc);
        SRC_EOF = 1'b0;
        n_vec++;
        if (dc != run_c + 2 || IN_CNT !== 16'd0 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL zero_run: got end_cyc=%0d in=%0d err=%b want %0d/0/0", dc, IN_CNT, ERR, run_c + 2);
        end
    endtask

    task automatic test_shadow();
        int dc;
        start_run(20, 1'b0, 2'd0, '0);
        repeat (5) tick();
        cfg_write(2'd2, 10'd100);
        wait_done(100, dc);
        n_vec++;
        if (B0 !== 10'd215) begin
            n_err++; $display("FAIL shadow_isolation: got B0=%0d want 215", B0);
        end
        start_run(20, 1'b1, 2'd1, 10'd5);
        n_vec++;
        if (B0 !== 10'd100 || A1 !== 10'd82) begin
            n_err++; $display("FAIL shadow_commit: got B0=%0d A1=%0d want 100/82", B0, A1);
        end
        wait_done(100, dc);
    endtask

    task automatic test_timeout();
        int dc;
        drop_k = 5;
        start_run(10, 1'b0, 2'd0, '0);
        n_vec++;
        if (A1 !== 10'd5) begin
            n_err++; $display("FAIL load_write_next_run: got A1=%0d want 5", A1);
        end
        wait_done(60, dc);
        drop_k = -1;
        n_vec++;
        if (dc != last_vin_cyc + 7) begin
            n_err++; $display("FAIL timeout_timing: got cycle %0d want %0d", dc, last_vin_cyc + 7);
        end
        n_vec++;
        if (ERR !== 1'b1 || OUT_CNT !== 16'd9 || IN_CNT !== 16'd10) begin
            n_err++; $display("FAIL timeout_status: got err=%b out=%0d in=%0d want 1/9/10", ERR, OUT_CNT, IN_CNT);
        end
        start_run(3, 1'b0, 2'd0, '0);
        wait_done(30, dc);
        n_vec++;
        if (ERR !== 1'b0 || OUT_CNT !== 16'd3) begin
            n_err++; $display("FAIL err_cleared: got err=%b out=%0d want 0/3", ERR, OUT_CNT);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        start_run(100, 1'b0, 2'd0, '0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (IN_CNT === 16'd20) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!hit) begin
            n_err++; $display("FAIL reach_in20: got in=%0d want 20", IN_CNT);
        end
        RST = 1'b1; START = 1'b1;
        tick();
        n_vec++;
        if ({SRC_EN, FLT_VIN, BUSY} !== 3'b000 || {A0, A1, B0, B1, IN_CNT} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got en/vin/busy=%b coef_cnt=%h want 000/0", {SRC_EN, FLT_VIN, BUSY}, {A0, A1, B0, B1, IN_CNT});
        end
        tick();
        RST = 1'b0; START = 1'b0;
        tick();
        n_vec++;
        if (BUSY !== 1'b0 || END_SIM !== 1'b0) begin
            n_err++; $display("FAIL start_during_rst: got busy=%b end=%b want 0/0", BUSY, END_SIM);
        end
        repeat (4) tick();
        stamp_q.delete();
        sh = '{default: '0};
        ex = '{default: '0};
    endtask

    task automatic test_spurious();
        int dc;
        tick();
        flt_force = 1'b1;
        repeat (3) tick();
        flt_force = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (OUT_CNT !== 16'd0 || BUSY !== 1'b0) begin
            n_err++; $display("FAIL idle_vout: got out=%0d busy=%b want 0/0", OUT_CNT, BUSY);
        end
        start_run(30, 1'b0, 2'd0, '0);
        repeat (5) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        n_vec++;
        if (BUSY !== 1'b1 || SRC_EN !== 1'b1 || IN_CNT !== 16'd6) begin
            n_err++; $display("FAIL start_in_run: got busy=%b src_en=%b in=%0d want 1/1/6", BUSY, SRC_EN, IN_CNT);
        end
        wait_done(100, dc);
        n_vec++;
        if (tb_issue != 30 || IN_CNT !== 16'd30 || OUT_CNT !== 16'd30) begin
            n_err++; $display("FAIL spurious_run: got vin=%0d in=%0d out=%0d want 30", tb_issue, IN_CNT, OUT_CNT);
        end
    endtask

    initial begin
        repeat (2) tick();
        test_reset();
        RST = 1'b0;
        test_basic();
        test_eof();
        test_zero();
        test_shadow();
        test_timeout();
        test_reset_mid();
        test_spurious();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule
